// File: rtl/alu_result_queue.sv
// rtl/alu_result_queue.sv - FIFO of ALU results with flags and overflow statistics
module alu_result_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_overflow,
    input  logic                       in_zero,
    input  logic                       in_negative,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_overflow,
    output logic                       out_zero,
    output logic                       out_negative,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    input  logic                       clear_sticky,
    output logic                       sticky_ovf,
    output logic [7:0]                 ovf_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = WIDTH + 3;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          sticky_q, sticky_d;
    logic [7:0]    ovf_cnt_q, ovf_cnt_d;
    logic          push, pop;
    logic [EW-1:0] head;

    assign in_ready  = (count_q != FULL);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Empty slots read as zero so the outputs are never X, even before the first push.
    assign head         = out_valid ? mem_q[rd_ptr_q] : '0;
    assign out_data     = head[EW-1:3];
    assign out_overflow = head[2];
    assign out_zero     = head[1];
    assign out_negative = head[0];

    assign count     = count_q;
    assign sticky_ovf = sticky_q;
    assign ovf_count = ovf_cnt_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        sticky_d  = sticky_q;
        ovf_cnt_d = ovf_cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
        if (clear_sticky) begin
            sticky_d  = 1'b0;
            ovf_cnt_d = 8'd0;
        end else if (push && in_overflow) begin
            sticky_d = 1'b1;
            if (ovf_cnt_q != 8'hFF) ovf_cnt_d = ovf_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            sticky_q  <= 1'b0;
            ovf_cnt_q <= 8'd0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            sticky_q  <= sticky_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= {in_data, in_overflow, in_zero, in_negative};
    end
endmodule

// File: tb/tb_alu_result_queue.sv
// tb/tb_alu_result_queue.sv - randomized self-checking bench for alu_result_queue
module tb_alu_result_queue;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid, in_overflow, in_zero, in_negative;
    logic [31:0] in_data;
    logic        in_ready, out_valid, out_overflow, out_zero, out_negative;
    logic [31:0] out_data;
    logic        out_ready, clear_sticky, sticky_ovf;
    logic [2:0]  count;
    logic [7:0]  ovf_count;

    int total = 0;
    int bad   = 0;

    logic [34:0] mq[$];
    logic        m_sticky;
    int          m_ovf;

    alu_result_queue #(.DEPTH(4), .WIDTH(32)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_data(in_data), .in_overflow(in_overflow),
        .in_zero(in_zero), .in_negative(in_negative), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_overflow(out_overflow),
        .out_zero(out_zero), .out_negative(out_negative), .out_ready(out_ready),
        .count(count), .clear_sticky(clear_sticky), .sticky_ovf(sticky_ovf),
        .ovf_count(ovf_count)
    );

    always #5 clock = ~clock;

    task automatic step(input logic v, input logic [31:0] d, input logic o, input logic z,
                        input logic n, input logic r, input logic c);
        int sz;
        bit pv, pp;
        sz = mq.size();
        in_valid = v; in_data = d; in_overflow = o; in_zero = z; in_negative = n;
        out_ready = r; clear_sticky = c;
        pv = v && (sz != 4);
        pp = r && (sz != 0);
        @(posedge clock);
        if (pp) void'(mq.pop_front());
        if (pv) mq.push_back({d, o, z, n});
        if (c) begin
            m_sticky = 1'b0; m_ovf = 0;
        end else if (pv && o) begin
            m_sticky = 1'b1;
            if (m_ovf < 255) m_ovf++;
        end
        #1;
        in_valid = 1'b0; out_ready = 1'b0; clear_sticky = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #3;
        mq.delete(); m_sticky = 1'b0; m_ovf = 0;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        in_valid = 0; in_data = '0; in_overflow = 0; in_zero = 0; in_negative = 0;
        out_ready = 0; clear_sticky = 0;
        reset_n = 1'b0;
        #2;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (out_data !== 32'd0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
        total++; if (sticky_ovf !== 1'b0 || ovf_count !== 8'd0) begin
            bad++; $display("FAIL reset_stats got=%b/%0d want=0/0", sticky_ovf, ovf_count); end
        mq.delete(); m_sticky = 1'b0; m_ovf = 0;
        @(negedge clock);
        reset_n = 1'b1;
        step(1, 32'h0000_00AB, 0, 0, 0, 0, 0);
        total++; if (count !== 3'd1 || out_data !== 32'hAB) begin
            bad++; $display("FAIL first_push got=%0d/%h want=1/ab", count, out_data); end
    endtask

    task automatic test_flags();
        do_reset();
        step(1, 32'd12, 0, 0, 0, 0, 0);
        step(1, 32'h8000_0000, 1, 0, 1, 0, 0);
        total++; if (count !== 3'd2) begin bad++; $display("FAIL flags_count got=%0d want=2", count); end
        total++; if (out_data !== 32'd12 || {out_overflow, out_zero, out_negative} !== 3'b000) begin
            bad++; $display("FAIL flags_head got=%h/%b want=c/000", out_data, {out_overflow, out_zero, out_negative}); end
        total++; if (sticky_ovf !== 1'b1 || ovf_count !== 8'd1) begin
            bad++; $display("FAIL flags_stats got=%b/%0d want=1/1", sticky_ovf, ovf_count); end
        step(0, 0, 0, 0, 0, 1, 0);
        total++; if (out_data !== 32'h8000_0000 || {out_overflow, out_zero, out_negative} !== 3'b101) begin
            bad++; $display("FAIL flags_second got=%h/%b want=80000000/101", out_data, {out_overflow, out_zero, out_negative}); end
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1, 32'(200 + i), 0, 1, 0, 0, 0);
            if (i == 3) begin
                total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%b want=0", in_ready); end
            end
        end
        total++; if (count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d want=4", count); end
        for (int i = 0; i < 4; i++) begin
            total++; if (out_data !== 32'(200 + i) || out_zero !== 1'b1) begin
                bad++; $display("FAIL drain_order[%0d] got=%0d want=%0d", i, out_data, 200 + i); end
            step(0, 0, 0, 0, 0, 1, 0);
        end
        total++; if (count !== 3'd0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL drain_empty got=%0d/%b want=0/0", count, out_valid); end
        step(0, 0, 0, 0, 0, 1, 0);
        total++; if (count !== 3'd0) begin bad++; $display("FAIL pop_empty got=%0d want=0", count); end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 32'(300 + i), 0, 0, 0, 0, 0);
        step(1, 32'd999, 0, 0, 0, 1, 0);
        total++; if (count !== 3'd3 || out_data !== 32'd301) begin
            bad++; $display("FAIL full_pop got=%0d/%0d want=3/301", count, out_data); end
        step(1, 32'd999, 0, 0, 0, 0, 0);
        total++; if (count !== 3'd4) begin bad++; $display("FAIL full_repush got=%0d want=4", count); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1, 32'(100 + i), 0, 0, 0, 1, 0);
            total++; if (count !== 3'd1 || out_data !== 32'(100 + i)) begin
                bad++; $display("FAIL stream[%0d] got=%0d/%0d want=1/%0d", i, count, out_data, 100 + i); end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 300; i++) step(1, $urandom, 1, 0, 0, 1, 0);
        total++; if (ovf_count !== 8'd255 || sticky_ovf !== 1'b1) begin
            bad++; $display("FAIL saturate got=%0d/%b want=255/1", ovf_count, sticky_ovf); end
    endtask

    task automatic test_clear();
        do_reset();
        step(1, 32'd7, 1, 0, 0, 0, 0);
        step(1, 32'd8, 1, 0, 0, 0, 1);
        total++; if (ovf_count !== 8'd0 || sticky_ovf !== 1'b0 || count !== 3'd2) begin
            bad++; $display("FAIL clear_override got=%0d/%b/%0d want=0/0/2", ovf_count, sticky_ovf, count); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) step(1, $urandom, 0, 0, 0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        total++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'd0) begin
            bad++; $display("FAIL async_reset got=%0d/%b/%b/%h want=0/0/1/0", count, out_valid, in_ready, out_data); end
        mq.delete(); m_sticky = 1'b0; m_ovf = 0;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_random();
        logic [2:0]  ec;
        logic [34:0] h;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 30) == 0);
            ec = 3'(mq.size());
            total++; if (count !== ec || in_ready !== (ec != 3'd4) || out_valid !== (ec != 3'd0)) begin
                bad++; $display("FAIL rand_occ[%0d] got=%0d/%b/%b want=%0d", i, count, in_ready, out_valid, ec); end
            if (ec != 3'd0) begin
                h = mq[0];
                total++; if ({out_data, out_overflow, out_zero, out_negative} !== h) begin
                    bad++; $display("FAIL rand_head[%0d] got=%h want=%h", i,
                                    {out_data, out_overflow, out_zero, out_negative}, h); end
            end
            total++; if (sticky_ovf !== m_sticky || ovf_count !== 8'(m_ovf)) begin
                bad++; $display("FAIL rand_stats[%0d] got=%b/%0d want=%b/%0d", i, sticky_ovf, ovf_count, m_sticky, m_ovf); end
        end
    endtask

    initial begin
        test_reset();
        test_flags();
        test_fill_drain();
        test_full_pop();
        test_back_to_back();
        test_saturate();
        test_clear();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_result_queue.md
ALU_RESULT_QUEUE -- requirements
Module: alu_result_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; SHALL be a power of two, 2 or more.
REQ-002 Parameter WIDTH, default 32, ALU result width.
REQ-003 clock  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  ALU result present this cycle.
REQ-006 in_data  input  WIDTH  ALU out.
REQ-007 in_overflow / in_zero / in_negative  input  1 each  ALU flags.
REQ-008 in_ready  output  1  queue can accept an entry.
REQ-009 out_valid  output  1  head entry valid.
REQ-010 out_data  output  WIDTH  head result.
REQ-011 out_overflow / out_zero / out_negative  output  1 each  head flags.
REQ-012 out_ready  input  1  consumer takes head this cycle.
REQ-013 count  output  clog2(DEPTH)+1  occupied entries.
REQ-014 clear_sticky  input  1  synchronous clear of overflow statistics.
REQ-015 sticky_ovf  output  1  an overflowed result has been accepted since the last clear.
REQ-016 ovf_count  output  8  saturating count of accepted overflowed results.

Function
REQ-017 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-018 in_ready SHALL be exactly (count != DEPTH), registered-state only, with no combinational path from out_ready.
REQ-019 out_valid SHALL be exactly (count != 0); out_data and flags SHALL show the oldest entry, combinationally from storage.
REQ-020 Latency: a result pushed in cycle N SHALL first appear at the outputs in cycle N+1; no same-cycle bypass, including when empty.
REQ-021 Each entry SHALL store {data, overflow, zero, negative} unchanged; the block SHALL NOT recompute flags.
REQ-022 Read and write pointers SHALL be clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-023 Simultaneous push and pop with 0<count<DEPTH: both occur and count is unchanged.
REQ-024 Push and pop in the same cycle when empty: only the push occurs, since out_valid=0.
REQ-025 Full: in_ready=0, and a push attempted while out_ready=1 is still refused that cycle.
REQ-026 in_valid while full SHALL be ignored with no state change; upstream must hold the result.
REQ-027 Pop when empty SHALL be ignored.
REQ-028 On every accepted push with in_overflow=1: sticky_ovf <- 1 and ovf_count <- min(ovf_count+1, 255).
REQ-029 clear_sticky=1 SHALL zero sticky_ovf and ovf_count next edge, overriding a same-cycle overflow push; that push still enters the queue.
REQ-030 out_* values with out_valid=0 are don't-care to the consumer but SHALL NOT be X after reset.

Reset
REQ-031 reset_n low SHALL immediately, without a clock edge, set these to 0: count, both pointers, sticky_ovf, ovf_count, out_valid.
REQ-032 reset_n low SHALL immediately set in_ready=1 (DEPTH>0).
REQ-033 Storage contents need no reset; out_data SHALL read 0 during and after reset until the first push.
REQ-034 Reset asserted mid-operation SHALL discard all queued entries.
REQ-035 First push SHALL be accepted on the first rising edge after reset_n deasserts.

Verification
REQ-036 Push 12 (flags 0,0,0), then push 0x80000000 (ovf=1, neg=1), out_ready=0 -> count=2, head=12, sticky_ovf=1, ovf_count=1.
REQ-037 Push 5 values with out_ready=0 -> count=4, in_ready=0 after the 4th, 5th ignored; then pop 4 -> values emerge in order, count=0, out_valid=0.
REQ-038 Full with in_valid=1 and out_ready=1 in one cycle -> pop only, count=3; next cycle push accepted, count=4.
REQ-039 Stream 10 entries with in_valid=out_ready=1 continuously -> pointers wrap, order preserved, steady count=1.
REQ-040 Reset: 300 overflow pushes -> ovf_count=255, saturated.
REQ-041 Reset: clear_sticky during an overflow push -> ovf_count=0 and entry queued.
REQ-042 Reset: reset_n low between edges with count=3 -> count=0, out_valid=0, in_ready=1 without a clock edge.
